tcdm_lic_xbar: RTL and testbench

//  Logarithmic crossbar between NumMaster cores and NumSlave word-interleaved TCDM banks.
//  Per master: bank decode from address, request routing, response return.
//  Per bank: round-robin arbitration.

---
 rtl/tcdm_lic_xbar.sv | 168 ++++++++++++++++
 tb/tb_tcdm_lic_xbar.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_lic_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tcdm_lic_xbar
//  Description : Logarithmic interconnect between NUM_MASTER initiators and
//                NUM_SLAVE word-interleaved TCDM banks. Each bank has its own
//                round-robin arbiter; responses return MEM_LATENCY cycles after
//                the grant through a per-master {valid, bank} shift register.
//                Optional macro TCDM_LIC_RESP_REG_EN adds an output register
//                on rvld_o/rdata_o (latency MEM_LATENCY+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tcdm_lic_xbar #(
    parameter int NUM_MASTER     = 4,
    parameter int NUM_SLAVE      = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH/8,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_MASTER-1:0]              req_i,
    input  logic [NUM_MASTER*ADDR_WIDTH-1:0]   add_i,
    input  logic [NUM_MASTER-1:0]              wen_i,
    input  logic [NUM_MASTER*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_MASTER*BE_WIDTH-1:0]     be_i,
    output logic [NUM_MASTER-1:0]              gnt_o,
    output logic [NUM_MASTER-1:0]              rvld_o,
    output logic [NUM_MASTER*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_SLAVE-1:0]               cs_o,
    output logic [NUM_SLAVE*ADDR_MEM_WIDTH-1:0] add_o,
    output logic [NUM_SLAVE-1:0]               wen_o,
    output logic [NUM_SLAVE*DATA_WIDTH-1:0]    wdata_o,
    output logic [NUM_SLAVE*BE_WIDTH-1:0]      be_o,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0]    rdata_i
);

    localparam int c_OFF   = $clog2(DATA_WIDTH/8);
    localparam int c_SEL_W = $clog2(NUM_SLAVE);
    localparam int c_PTR_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    logic [c_SEL_W-1:0]        w_bank [NUM_MASTER];
    logic [ADDR_MEM_WIDTH-1:0] w_word [NUM_MASTER];
    logic [NUM_SLAVE-1:0]      w_cs;
    logic [c_PTR_W-1:0]        w_win  [NUM_SLAVE];
    logic [c_PTR_W-1:0]        r_ptr  [NUM_SLAVE];
    logic [NUM_MASTER-1:0]     w_gnt;
    logic                      w_unused;

    // Offset bits and address bits above the bank word are not decoded.
    assign w_unused = ^add_i;

    // Split each master address into bank select and in-bank word address.
    always_comb begin
        for (int j = 0; j < NUM_MASTER; j++) begin
            w_bank[j] = add_i[j*ADDR_WIDTH + c_OFF +: c_SEL_W];
            w_word[j] = add_i[j*ADDR_WIDTH + c_OFF + c_SEL_W +: ADDR_MEM_WIDTH];
        end
    end

    // Per-bank round robin: first requester at or after the pointer wins.
    always_comb begin
        int v_idx;
        v_idx = 0;
        for (int k = 0; k < NUM_SLAVE; k++) begin
            w_cs[k]  = 1'b0;
            w_win[k] = '0;
            for (int i = 0; i < NUM_MASTER; i++) begin
                v_idx = (int'(r_ptr[k]) + i) % NUM_MASTER;
                if (!w_cs[k] && req_i[v_idx] && (w_bank[v_idx] == c_SEL_W'(k))) begin
                    w_cs[k]  = 1'b1;
                    w_win[k] = c_PTR_W'(v_idx);
                end
            end
        end
    end

    // A master is granted when it is the winner of the bank it addresses.
    always_comb begin
        for (int j = 0; j < NUM_MASTER; j++) begin
            w_gnt[j] = req_i[j] && w_cs[w_bank[j]] && (w_win[w_bank[j]] == c_PTR_W'(j));
        end
    end

    assign gnt_o = w_gnt;
    assign cs_o  = w_cs;

    // Steer the winner's payload to each bank; idle banks see all zeros.
    always_comb begin
        add_o   = '0;
        wen_o   = '0;
        wdata_o = '0;
        be_o    = '0;
        for (int k = 0; k < NUM_SLAVE; k++) begin
            if (w_cs[k]) begin
                add_o[k*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = w_word[w_win[k]];
                wen_o[k]                                  = wen_i[w_win[k]];
                wdata_o[k*DATA_WIDTH +: DATA_WIDTH]       = wdata_i[int'(w_win[k])*DATA_WIDTH +: DATA_WIDTH];
                be_o[k*BE_WIDTH +: BE_WIDTH]              = be_i[int'(w_win[k])*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // Move each bank's pointer past the master it just served.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_SLAVE; k++) begin
            if (rst_i) begin
                r_ptr[k] <= '0;
            end else if (w_cs[k]) begin
                r_ptr[k] <= c_PTR_W'((int'(w_win[k]) + 1) % NUM_MASTER);
            end
        end
    end

    generate
        for (genvar gj = 0; gj < NUM_MASTER; gj++) begin : g_resp
            logic [MEM_LATENCY-1:0] r_vld;
            logic [c_SEL_W-1:0]     r_bnk [MEM_LATENCY];
            logic                   w_vld;
            logic [DATA_WIDTH-1:0]  w_data;

            // Carry {valid, bank} of each grant down the latency pipeline.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_vld <= '0;
                    for (int s = 0; s < MEM_LATENCY; s++) r_bnk[s] <= '0;
                end else begin
                    r_vld[0] <= w_gnt[gj];
                    r_bnk[0] <= w_bank[gj];
                    for (int s = 1; s < MEM_LATENCY; s++) begin
                        r_vld[s] <= r_vld[s-1];
                        r_bnk[s] <= r_bnk[s-1];
                    end
                end
            end

            assign w_vld  = r_vld[MEM_LATENCY-1];
            assign w_data = w_vld ? rdata_i[int'(r_bnk[MEM_LATENCY-1])*DATA_WIDTH +: DATA_WIDTH]
                                  : '0;

`ifdef TCDM_LIC_RESP_REG_EN
            logic                  r_rvld;
            logic [DATA_WIDTH-1:0] r_rdata;

            // Optional retiming register on the response path.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rvld  <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_rvld  <= w_vld;
                    r_rdata <= w_data;
                end
            end

            assign rvld_o[gj]                          = r_rvld;
            assign rdata_o[gj*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
`else
            assign rvld_o[gj]                          = w_vld;
            assign rdata_o[gj*DATA_WIDTH +: DATA_WIDTH] = w_data;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tcdm_lic_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tcdm_lic_xbar
//  Description : Self-checking bench for tcdm_lic_xbar. Three instances with
//                MEM_LATENCY 1, 2 and 3 share one stimulus stream; a reference
//                round-robin model predicts grants and pushes expected
//                responses to a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_lic_xbar;

    localparam int NM = 4;
    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MW = 12;
    localparam int ND = 3;
`ifdef TCDM_LIC_RESP_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic [NM-1:0]     req_i;
    logic [NM*AW-1:0]  add_i;
    logic [NM-1:0]     wen_i;
    logic [NM*DW-1:0]  wdata_i;
    logic [NM*BW-1:0]  be_i;
    logic [NS*DW-1:0]  rdata_i;

    logic [NM-1:0]     gnt_a   [ND];
    logic [NM-1:0]     rvld_a  [ND];
    logic [NM*DW-1:0]  rdata_a [ND];
    logic [NS-1:0]     cs_a    [ND];
    logic [NS*MW-1:0]  addo_a  [ND];
    logic [NS-1:0]     weno_a  [ND];
    logic [NS*DW-1:0]  wdo_a   [ND];
    logic [NS*BW-1:0]  beo_a   [ND];

    generate
        for (genvar d = 0; d < ND; d++) begin : g_dut
            tcdm_lic_xbar #(
                .NUM_MASTER(NM), .NUM_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                .BE_WIDTH(BW), .ADDR_MEM_WIDTH(MW), .MEM_LATENCY(d+1)
            ) u_dut (
                .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i),
                .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
                .gnt_o(gnt_a[d]), .rvld_o(rvld_a[d]), .rdata_o(rdata_a[d]),
                .cs_o(cs_a[d]), .add_o(addo_a[d]), .wen_o(weno_a[d]),
                .wdata_o(wdo_a[d]), .be_o(beo_a[d]), .rdata_i(rdata_i)
            );
        end
    endgenerate

    typedef struct {
        int d;
        int m;
        int due;
        int bank;
    } exp_t;

    exp_t          sb[$];
    int            m_ptr [NS];
    int            cyc;
    int            n_cmp;
    int            n_err;
    logic [NM-1:0] s_req;
    logic [NM-1:0] s_wen;
    logic [31:0]   s_add [NM];
    logic [31:0]   s_wd  [NM];
    logic [3:0]    s_be  [NM];

    function automatic int bank_of(input logic [31:0] a);
        return int'(a[4:2]);
    endfunction

    function automatic logic [11:0] word_of(input logic [31:0] a);
        return a[16:5];
    endfunction

    // Bank read data is a function of cycle and bank so responses are traceable.
    function automatic logic [31:0] dfn(input int c, input int k);
        return {16'(c), 8'hD0, 8'(k)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict, compare, update model and scoreboard.
    task automatic step(input logic r);
        int            win [NS];
        int            idx;
        logic [NM-1:0] exp_gnt;
        logic [NS-1:0] exp_cs;
        logic          found;
        int            fb;
        @(negedge clk);
        cyc++;
        rst_i = r;
        req_i = s_req;
        wen_i = s_wen;
        for (int m = 0; m < NM; m++) begin
            add_i[m*AW +: AW]   = s_add[m];
            wdata_i[m*DW +: DW] = s_wd[m];
            be_i[m*BW +: BW]    = s_be[m];
        end
        for (int k = 0; k < NS; k++) rdata_i[k*DW +: DW] = dfn(cyc, k);
        #1;
        exp_gnt = '0;
        exp_cs  = '0;
        for (int k = 0; k < NS; k++) begin
            win[k] = -1;
            for (int i = 0; i < NM; i++) begin
                idx = (m_ptr[k] + i) % NM;
                if (win[k] < 0 && s_req[idx] && bank_of(s_add[idx]) == k) win[k] = idx;
            end
            if (win[k] >= 0) begin
                exp_gnt[win[k]] = 1'b1;
                exp_cs[k]       = 1'b1;
            end
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("gnt d%0d c%0d", d, cyc), 64'(gnt_a[d]), 64'(exp_gnt));
            chk($sformatf("cs d%0d c%0d", d, cyc), 64'(cs_a[d]), 64'(exp_cs));
        end
        for (int k = 0; k < NS; k++) begin
            if (win[k] >= 0)
                chk($sformatf("bank%0d c%0d", k, cyc),
                    64'({addo_a[0][k*MW +: MW], weno_a[0][k], wdo_a[0][k*DW +: DW], beo_a[0][k*BW +: BW]}),
                    64'({word_of(s_add[win[k]]), s_wen[win[k]], s_wd[win[k]], s_be[win[k]]}));
            else
                chk($sformatf("bank%0d idle c%0d", k, cyc),
                    64'({addo_a[0][k*MW +: MW], weno_a[0][k], wdo_a[0][k*DW +: DW], beo_a[0][k*BW +: BW]}),
                    64'(0));
        end
        for (int d = 0; d < ND; d++) begin
            for (int m = 0; m < NM; m++) begin
                found = 1'b0;
                fb    = 0;
                for (int q = 0; q < sb.size(); q++) begin
                    if (sb[q].d == d && sb[q].m == m && sb[q].due == cyc) begin
                        found = 1'b1;
                        fb    = sb[q].bank;
                        sb.delete(q);
                        break;
                    end
                end
                chk($sformatf("rvld d%0d m%0d c%0d", d, m, cyc), 64'(rvld_a[d][m]), 64'(found));
                chk($sformatf("rdata d%0d m%0d c%0d", d, m, cyc), 64'(rdata_a[d][m*DW +: DW]),
                    found ? 64'(dfn(cyc - EXTRA, fb)) : 64'(0));
            end
        end
        if (r) begin
            sb.delete();
            for (int k = 0; k < NS; k++) m_ptr[k] = 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (win[k] >= 0) begin
                    for (int d = 0; d < ND; d++) sb.push_back('{d, win[k], cyc + d + 1 + EXTRA, k});
                    m_ptr[k] = (win[k] + 1) % NM;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        s_req = '0;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        rst_i   = 1'b1;
        req_i   = '0;
        add_i   = '0;
        wen_i   = '0;
        wdata_i = '0;
        be_i    = '0;
        rdata_i = '0;
        cyc     = 0;
        n_cmp   = 0;
        n_err   = 0;
        s_req   = '0;
        s_wen   = '0;
        for (int k = 0; k < NS; k++) m_ptr[k] = 0;
        for (int m = 0; m < NM; m++) begin
            s_add[m] = '0;
            s_wd[m]  = 32'h1000_0000 + 32'(m);
            s_be[m]  = 4'hF;
        end

        // Reset: outputs idle, response path cleared.
        step(1'b1);
        step(1'b1);

        // Four loads to banks 0..3 all granted in parallel.
        s_req = 4'hF;
        s_wen = 4'hF;
        for (int m = 0; m < NM; m++) s_add[m] = 32'(m * 4);
        step(1'b0);
        chk("t1 gnt", 64'(gnt_a[0]), 64'h0F);
        chk("t1 cs", 64'(cs_a[0]), 64'h0F);
        chk("t1 add_o", 64'(addo_a[0][4*MW-1:0]), 64'h0);
        idle(4);

        // Two stores collide on bank 0 word 1.
        step(1'b1);
        s_req    = 4'b0101;
        s_wen    = 4'b0000;
        s_add[0] = 32'h20;
        s_add[2] = 32'h20;
        s_wd[0]  = 32'hAAAA_0000;
        s_wd[2]  = 32'hBBBB_2222;
        s_be[2]  = 4'h3;
        step(1'b0);
        chk("t2 gnt c0", 64'(gnt_a[0]), 64'b0001);
        chk("t2 add_o0", 64'(addo_a[0][MW-1:0]), 64'h1);
        chk("t2 wen_o0", 64'(weno_a[0][0]), 64'h0);
        s_req = 4'b0100;
        step(1'b0);
        chk("t2 gnt c1", 64'(gnt_a[0]), 64'b0100);
        s_req    = 4'b1010;
        s_wen    = 4'b1010;
        s_add[1] = 32'h20;
        s_add[3] = 32'h20;
        step(1'b0);
        chk("t2 ptr3", 64'(gnt_a[0]), 64'b1000);
        s_req = 4'b0010;
        step(1'b0);
        idle(4);

        // All masters hammer bank 5.
        s_req = 4'hF;
        s_wen = 4'b1010;
        for (int m = 0; m < NM; m++) s_add[m] = 32'h14 + 32'(m << 5);
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            chk($sformatf("t3 rr %0d", i), 64'(gnt_a[0]), 64'(1 << (i % 4)));
        end
        idle(4);

        // Back-to-back loads from M1 to bank 5 (checked on all latencies).
        s_req    = 4'b0010;
        s_wen    = 4'hF;
        s_add[1] = 32'h14;
        step(1'b0);
        step(1'b0);
        idle(6);

        // Reset one cycle after a grant drops the response and rewinds pointers.
        s_req    = 4'b0010;
        s_add[1] = 32'h18;
        step(1'b0);
        s_req    = 4'b1000;
        s_add[3] = 32'h1C;
        step(1'b1);
        chk("t5 gnt in rst", 64'(gnt_a[0]), 64'b1000);
        s_req    = 4'b0101;
        s_add[0] = 32'h18;
        s_add[2] = 32'h38;
        step(1'b0);
        chk("t5 gnt after rst", 64'(gnt_a[0]), 64'b0001);
        idle(5);

        // Mixed traffic across a few banks.
        for (int i = 0; i < 40; i++) begin
            s_req = 4'($urandom_range(0, 15));
            s_wen = 4'($urandom_range(0, 15));
            for (int m = 0; m < NM; m++) begin
                s_add[m] = 32'($urandom) & 32'h0001_FF0C;
                s_wd[m]  = 32'($urandom);
                s_be[m]  = 4'($urandom_range(0, 15));
            end
            step(1'b0);
        end
        idle(6);
        chk("sb empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
